io_tx_port: RTL and testbench

- Downstream consumer of the processor datapath's 16-bit ioOut bus.
- Detects each new output word and queues it in a small FIFO.
- Serialises each queued word onto a single UART-style TX line: low byte first, 8N1 framing, LSB first.
- Gives the processor a real serial output without any change to the control unit.

---
 rtl/io_tx_port.sv | 154 +++++++++++++++
 tb/tb_io_tx_port.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/io_tx_port.sv
`default_nettype none
// io_tx_port: queues each change of the 16-bit ioOut bus and serialises it on tx, low byte first, LSB first.
// Framing is 8N1; defining IO_TX_PARITY_EN adds an even-parity bit (8E1).
module io_tx_port #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_AW      = 2
) (
  input  logic               clk,
  input  logic               Reset_n,
  input  logic [15:0]        ioOut,
  input  logic               clear_ovf,
  output logic               tx,
  output logic               busy,
  output logic [FIFO_AW:0]   fifo_count,
  output logic               overflow
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int TW    = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0]    TIMER_LOAD = TW'(CLKS_PER_BIT - 1);
  localparam logic [FIFO_AW:0] COUNT_FULL = (FIFO_AW + 1)'(DEPTH);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_STOP   = 3'd4;
`ifdef IO_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
  logic                  parity;
`endif

  logic [15:0]        last_word;
  logic [15:0]        mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [2:0]         state, state_next;
  logic [TW-1:0]      timer;
  logic [2:0]         bit_idx;
  logic               hi;
  logic [15:0]        shreg;
  logic               tx_next, busy_next;
  logic               change, full, pop, push_ok, tick;

  assign change  = (ioOut != last_word);
  assign full    = (fifo_count == COUNT_FULL);
  assign pop     = (state == S_IDLE) && (fifo_count != '0);
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign push_ok = change && (!full || pop);
  assign tick    = (timer == '0);

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      last_word  <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (change)  last_word <= ioOut;
      if (push_ok) wr_ptr    <= wr_ptr + 1'b1;
      if (pop)     rd_ptr    <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
      if (change && full && !pop) overflow <= 1'b1;
      else if (clear_ovf)         overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= ioOut;
  end

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= S_IDLE;
      tx    <= 1'b1;
      busy  <= 1'b0;
    end else begin
      state <= state_next;
      tx    <= tx_next;
      busy  <= busy_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (fifo_count != '0) state_next = S_START;
      S_START: if (tick) state_next = S_DATA;
      S_DATA:  if (tick && bit_idx == 3'd7) begin
`ifdef IO_TX_PARITY_EN
        state_next = S_PARITY;
`else
        state_next = S_STOP;
`endif
      end
`ifdef IO_TX_PARITY_EN
      S_PARITY: if (tick) state_next = S_STOP;
`endif
      S_STOP:  if (tick) state_next = hi ? S_IDLE : S_START;
      default: state_next = S_IDLE;
    endcase
  end

  // tx is registered, so it is driven from the state being entered and the bit that will be current then.
  always_comb begin
    tx_next   = 1'b1;
    busy_next = (state_next != S_IDLE);
    case (state_next)
      S_START:  tx_next = 1'b0;
      S_DATA:   tx_next = (state == S_DATA && tick) ? shreg[1] : shreg[0];
`ifdef IO_TX_PARITY_EN
      S_PARITY: tx_next = parity;
`endif
      default:  tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      timer   <= '0;
      bit_idx <= '0;
      hi      <= 1'b0;
      shreg   <= '0;
`ifdef IO_TX_PARITY_EN
      parity  <= 1'b0;
`endif
    end else begin
      if (state_next == S_IDLE)
        timer <= '0;
      else if (state_next != state || (state == S_DATA && tick))
        timer <= TIMER_LOAD;
      else if (!tick)
        timer <= timer - 1'b1;
      if (pop) begin
        shreg <= mem[rd_ptr];
        hi    <= 1'b0;
      end
`ifdef IO_TX_PARITY_EN
      if (state == S_START && tick) parity <= ^shreg[7:0];
`endif
      // After eight shifts the high byte sits in shreg[7:0], ready for the second frame.
      if (state == S_DATA && tick) begin
        shreg   <= shreg >> 1;
        bit_idx <= bit_idx + 1'b1;
      end
      if (state == S_STOP && tick && !hi) hi <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_io_tx_port.sv
`default_nettype none
// tb_io_tx_port: random and directed stimulus; a word-level timing model feeds a scoreboard
// that a UART receiver on tx drains, plus per-cycle checks of fifo_count, busy and overflow.
module tb_io_tx_port;

  localparam int CPB   = 4;
  localparam int AW    = 2;
  localparam int DEPTH = 1 << AW;
`ifdef IO_TX_PARITY_EN
  localparam int FBITS = 11;
`else
  localparam int FBITS = 10;
`endif
  localparam int WT = 2 * FBITS * CPB;

  logic        clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        clear_ovf = 1'b0;
  logic [15:0] ioOut = 16'h0000;
  logic        tx, busy, overflow;
  logic [AW:0] fifo_count;

  io_tx_port #(.CLKS_PER_BIT(CPB), .FIFO_AW(AW)) dut (
    .clk(clk), .Reset_n(Reset_n), .ioOut(ioOut), .clear_ovf(clear_ovf),
    .tx(tx), .busy(busy), .fifo_count(fifo_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] w;
    int          push;
    int          start;
  } ent_t;

  ent_t        acc[$];
  ent_t        rxq[$];
  logic [15:0] m_last = 16'h0000;
  bit          m_ovf = 1'b0;
  int          last_start = -100000;
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Words waiting in the FIFO after edge c: pushed by then, not yet popped.
  function automatic int m_occ(input int c);
    int n = 0;
    foreach (acc[i]) if (acc[i].push <= c && acc[i].start > c) n++;
    return n;
  endfunction

  function automatic bit m_busy(input int c);
    foreach (acc[i]) if (acc[i].start <= c && c < acc[i].start + WT) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_pop(input int e);
    foreach (acc[i]) if (acc[i].start == e) return 1'b1;
    return 1'b0;
  endfunction

  task automatic m_reset();
    acc.delete();
    rxq.delete();
    m_last     = 16'h0000;
    m_ovf      = 1'b0;
    last_start = -100000;
  endtask

  // Drive one cycle of inputs and predict what the following rising edge does.
  task automatic tick(input logic [15:0] v, input bit clr);
    int   e;
    bit   dropped;
    ent_t en;
    @(negedge clk);
    ioOut     = v;
    clear_ovf = clr;
    e         = cyc + 1;
    dropped   = 1'b0;
    while (acc.size() > 0 && acc[0].start + WT < e - 1) void'(acc.pop_front());
    if (v != m_last) begin
      m_last = v;
      if (m_occ(e - 1) == DEPTH && !m_pop(e)) begin
        dropped = 1'b1;
      end else begin
        en.w       = v;
        en.push    = e;
        en.start   = (e + 1 > last_start + WT + 1) ? e + 1 : last_start + WT + 1;
        last_start = en.start;
        acc.push_back(en);
        rxq.push_back(en);
      end
    end
    if (dropped)  m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
  endtask

  // Monitor: per-cycle status checks and a UART receiver that pops the scoreboard.
  bit          rx_act = 1'b0;
  bit          rx_hi = 1'b0;
  int          rx_t0, rx_lo_t0, off;
  logic [7:0]  rx_byte;
  ent_t        rx_cur;

  always @(posedge clk) begin
    #2;
    if (!Reset_n) begin
      rx_act = 1'b0;
      rx_hi  = 1'b0;
    end else begin
      chk("fifo_count", 32'(fifo_count), 32'(m_occ(cyc)));
      chk("busy", 32'(busy), 32'(m_busy(cyc)));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      if (!m_busy(cyc)) chk("tx_idle", 32'(tx), 32'd1);
      if (!rx_act) begin
        if (tx == 1'b0) begin
          rx_act = 1'b1;
          rx_t0  = cyc;
          if (!rx_hi) begin
            chk("lo_start_cycle", 32'(rx_t0), 32'((rxq.size() != 0) ? rxq[0].start : -1));
            if (rxq.size() != 0) rx_cur = rxq.pop_front();
            rx_lo_t0 = rx_t0;
          end else begin
            chk("hi_start_cycle", 32'(rx_t0), 32'(rx_lo_t0 + FBITS * CPB));
          end
        end
      end else begin
        off = cyc - rx_t0;
        if (off == CPB / 2) chk("start_bit", 32'(tx), 32'd0);
        for (int j = 1; j <= 8; j++) if (off == j * CPB + CPB / 2) rx_byte[j-1] = tx;
`ifdef IO_TX_PARITY_EN
        if (off == 9 * CPB + CPB / 2) chk("parity_bit", 32'(tx), 32'(^rx_byte));
`endif
        if (off == (FBITS - 1) * CPB + CPB / 2) begin
          chk("stop_bit", 32'(tx), 32'd1);
          if (rx_hi) chk("hi_byte", 32'(rx_byte), 32'(rx_cur.w[15:8]));
          else       chk("lo_byte", 32'(rx_byte), 32'(rx_cur.w[7:0]));
          rx_hi  = !rx_hi;
          rx_act = 1'b0;
        end
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while ((m_busy(cyc) || m_occ(cyc) != 0 || rxq.size() != 0 || rx_act || rx_hi) && n < 5000) begin
      tick(ioOut, 1'b0);
      n++;
    end
    chk("drain_within_bound", 32'(n < 5000), 32'd1);
    repeat (3) tick(ioOut, 1'b0);
  endtask

  initial begin
    logic [15:0] v;
    int          hold, s;
    repeat (3) @(negedge clk);
    Reset_n = 1'b1;
    repeat (200) tick(16'h0000, 1'b0);

    tick(16'hA55A, 1'b0);
    wait_idle();

    tick(16'h0001, 1'b0);
    tick(16'h0002, 1'b0);
    tick(16'h0003, 1'b0);
    wait_idle();

    tick(16'h1111, 1'b0);
    tick(16'h2222, 1'b0);
    tick(16'h3333, 1'b0);
    tick(16'h4444, 1'b0);
    tick(16'h5555, 1'b0);
    tick(16'h6666, 1'b1);
    @(posedge clk);
    #3;
    chk("count_after_six", 32'(fifo_count), 32'd4);
    chk("ovf_set_beats_clear", 32'(overflow), 32'd1);
    wait_idle();
    tick(16'h6666, 1'b1);
    @(posedge clk);
    #3;
    chk("ovf_cleared", 32'(overflow), 32'd0);

    tick(16'hBEEF, 1'b0);
    s = last_start;
    tick(16'h5A5A, 1'b0);
    tick(16'h7777, 1'b0);
    while (cyc < s + FBITS * CPB + 3 * CPB) tick(16'h7777, 1'b0);
    #1;
    Reset_n = 1'b0;
    ioOut   = 16'h0000;
    m_reset();
    #1;
    chk("reset_tx", 32'(tx), 32'd1);
    chk("reset_count", 32'(fifo_count), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    Reset_n = 1'b1;
    repeat (50) tick(16'h0000, 1'b0);
    tick(16'h1234, 1'b0);
    wait_idle();

    v = 16'h1234;
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 4) != 0) v = 16'($urandom);
      hold = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : $urandom_range(20, 120);
      tick(v, $urandom_range(0, 15) == 0);
      repeat (hold - 1) tick(v, 1'b0);
    end
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
